// File: rtl/abro_n_detector_if.sv
// Event/control bundle for abro_n_detector: event lines and restart in,
// completion status out.
interface abro_n_detector_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic [N-1:0]     A;
    logic             R;
    logic             O;
    logic [1:0]       state;
    logic [N-1:0]     seen;
    logic             timeout;
    logic [CNT_W-1:0] done_count;

    modport master (
        output A, R,
        input  O, state, seen, timeout, done_count
    );

    modport slave (
        input  A, R,
        output O, state, seen, timeout, done_count
    );
endinterface

// File: rtl/abro_n_detector.sv
// N-input ABRO detector: asserts O once every event line has been seen high,
// holds in DONE until restart, with optional collection timeout.
module abro_n_detector #(
    parameter int N          = 4,
    parameter int PULSE_MODE = 0,
    parameter int TIMEOUT    = 0,
    parameter int CNT_W      = 8
) (
    input logic              clk,
    input logic              reset_n,
    abro_n_detector_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [N-1:0]     ALL_SEEN = {N{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     seen_q;
    logic [N-1:0]     seen_d;
    logic [N-1:0]     nxt;
    logic             full;
    logic             expire;
    logic             enter_done;
    logic             o_q;
    logic             o_d;
    logic             timeout_q;
    logic             timeout_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign nxt  = seen_q | bus.A;
    assign full = (nxt == ALL_SEEN);

    // Collection timer exists only when a timeout is configured; it counts
    // completed COLLECT cycles and is cleared on every exit from COLLECT.
    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

            logic [TW-1:0] timer_q;

            assign expire = (state_q == COLLECT) && (timer_q == LAST);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    timer_q <= '0;
                end else if (!bus.R && (state_q == COLLECT) && !full && !expire) begin
                    timer_q <= timer_q + TW'(1);
                end else begin
                    timer_q <= '0;
                end
            end
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.R) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full) begin
                        state_d = DONE;
                    end else if (bus.A != '0) begin
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    // Completion beats expiry when both land on the same edge.
                    if (full) begin
                        state_d = DONE;
                    end else if (expire) begin
                        state_d = IDLE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        seen_d     = seen_q;
        enter_done = (state_d == DONE) && (state_q != DONE);
        timeout_d  = !bus.R && (state_q == COLLECT) && !full && expire;
        cnt_d      = cnt_q;

        if (bus.R) begin
            seen_d = '0;
        end else begin
            case (state_q)
                IDLE:    seen_d = nxt;
                COLLECT: seen_d = timeout_d ? '0 : nxt;
                DONE:    seen_d = ALL_SEEN;
                default: seen_d = '0;
            endcase
        end

        if (enter_done && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (PULSE_MODE != 0) begin
            o_d = enter_done;
        end else begin
            o_d = (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q    <= '0;
            o_q       <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            seen_q    <= seen_d;
            o_q       <= o_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.O          = o_q;
    assign bus.state      = state_q;
    assign bus.seen       = seen_q;
    assign bus.timeout    = timeout_q;
    assign bus.done_count = cnt_q;

endmodule

// File: tb/tb_abro_n_detector.sv
// Bench for abro_n_detector: four configurations share one stimulus stream and
// are compared each cycle against a behavioural model of the event rules.
module tb_abro_n_detector;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] a_in;
    logic       r_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    abro_n_detector_if #(.N(4), .CNT_W(8)) b0 ();
    abro_n_detector_if #(.N(4), .CNT_W(8)) b1 ();
    abro_n_detector_if #(.N(4), .CNT_W(8)) b2 ();
    abro_n_detector_if #(.N(4), .CNT_W(2)) b3 ();

    assign b0.A = a_in; assign b0.R = r_in;
    assign b1.A = a_in; assign b1.R = r_in;
    assign b2.A = a_in; assign b2.R = r_in;
    assign b3.A = a_in; assign b3.R = r_in;

    abro_n_detector #(.N(4), .PULSE_MODE(0), .TIMEOUT(0), .CNT_W(8)) d0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    abro_n_detector #(.N(4), .PULSE_MODE(1), .TIMEOUT(0), .CNT_W(8)) d1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    abro_n_detector #(.N(4), .PULSE_MODE(0), .TIMEOUT(5), .CNT_W(8)) d2 (.clk(clk), .reset_n(reset_n), .bus(b2));
    abro_n_detector #(.N(4), .PULSE_MODE(0), .TIMEOUT(0), .CNT_W(2)) d3 (.clk(clk), .reset_n(reset_n), .bus(b3));

    // Per-instance configuration and model state.
    int pulse[4] = '{0, 1, 0, 0};
    int tmo[4]   = '{0, 0, 5, 0};
    int cmax[4]  = '{255, 255, 255, 3};
    int m_state[4];
    int m_seen[4];
    int m_cyc[4];
    int m_o[4];
    int m_to[4];
    int m_cnt[4];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_state[k] = 0; m_seen[k] = 0; m_cyc[k] = 0;
            m_o[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
        end
    endfunction

    function automatic void model_step(input int a, input int r);
        for (int k = 0; k < 4; k++) begin
            int nxt;
            bit full;
            nxt  = m_seen[k] | a;
            full = (nxt == 15);
            m_to[k] = 0;
            if (r != 0) begin
                m_state[k] = 0; m_seen[k] = 0; m_cyc[k] = 0; m_o[k] = 0;
            end else if (m_state[k] == 2) begin
                m_o[k] = (pulse[k] != 0) ? 0 : 1;
            end else if (full) begin
                m_state[k] = 2; m_seen[k] = 15; m_o[k] = 1; m_cyc[k] = 0;
                if (m_cnt[k] < cmax[k]) m_cnt[k]++;
            end else if (m_state[k] == 0) begin
                m_o[k] = 0;
                if (a != 0) begin
                    m_state[k] = 1; m_seen[k] = a; m_cyc[k] = 0;
                end
            end else if (tmo[k] > 0 && m_cyc[k] == tmo[k] - 1) begin
                m_state[k] = 0; m_seen[k] = 0; m_cyc[k] = 0; m_to[k] = 1;
            end else begin
                m_seen[k] = nxt;
                m_cyc[k]++;
            end
        end
    endfunction

    task automatic chk_inst(input int k, input string tag, input int o, input int st,
                            input int sn, input int to, input int cnt);
        chk($sformatf("%s.d%0d.O", tag, k), o, m_o[k]);
        chk($sformatf("%s.d%0d.state", tag, k), st, m_state[k]);
        chk($sformatf("%s.d%0d.seen", tag, k), sn, m_seen[k]);
        chk($sformatf("%s.d%0d.timeout", tag, k), to, m_to[k]);
        chk($sformatf("%s.d%0d.done_count", tag, k), cnt, m_cnt[k]);
    endtask

    task automatic check_all(input string tag);
        chk_inst(0, tag, int'(b0.O), int'(b0.state), int'(b0.seen), int'(b0.timeout), int'(b0.done_count));
        chk_inst(1, tag, int'(b1.O), int'(b1.state), int'(b1.seen), int'(b1.timeout), int'(b1.done_count));
        chk_inst(2, tag, int'(b2.O), int'(b2.state), int'(b2.seen), int'(b2.timeout), int'(b2.done_count));
        chk_inst(3, tag, int'(b3.O), int'(b3.state), int'(b3.seen), int'(b3.timeout), int'(b3.done_count));
    endtask

    task automatic cycle(input string tag, input int a, input int r);
        a_in = a[3:0];
        r_in = (r != 0);
        @(posedge clk);
        model_step(a, r);
        #1;
        check_all(tag);
    endtask

    int sat_tbl[5] = '{1, 2, 3, 3, 3};

    initial begin
        reset_n = 1'b0;
        a_in    = '0;
        r_in    = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Saturating counter: five complete/restart rounds.
        for (int i = 0; i < 5; i++) begin
            cycle("sat_fill", 15, 0);
            chk($sformatf("sat_cnt%0d", i), int'(b3.done_count), sat_tbl[i]);
            cycle("sat_rst", 0, 1);
        end

        // Async reset clears counters as well.
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("rst_clear");
        reset_n = 1'b1;

        // Events in arbitrary order over several cycles.
        cycle("ord1", 1, 0);
        chk("ord1_state", int'(b0.state), 1);
        cycle("ord2", 4, 0);
        cycle("ord3", 2, 0);
        cycle("ord4", 8, 0);
        chk("ord_O", int'(b0.O), 1);
        chk("ord_cnt", int'(b0.done_count), 1);
        for (int i = 0; i < 4; i++) cycle("ord_hold", $urandom_range(0, 15), 0);
        cycle("ord_r", 0, 1);

        // Simultaneous completion, then a long hold and restart.
        cycle("sim", 15, 0);
        chk("sim_state", int'(b0.state), 2);
        for (int i = 0; i < 5; i++) cycle("sim_hold", 0, 0);
        cycle("sim_r", 0, 1);

        // Timeout expiry, then completion in the last allowed cycle.
        cycle("to_a", 3, 0);
        for (int i = 0; i < 6; i++) cycle("to_wait", 0, 0);
        cycle("to2_a", 3, 0);
        for (int i = 0; i < 4; i++) cycle("to2_wait", 0, 0);
        cycle("to2_last", 12, 0);
        chk("to2_state", int'(b2.state), 2);
        cycle("to2_r", 0, 1);

        // Restart wins over the final missing bit; back-to-back restart.
        cycle("rp_a", 1, 0);
        cycle("rp_r", 14, 1);
        chk("rp_O", int'(b0.O), 0);
        cycle("rp_b2b", 5, 0);

        // Async reset mid-collection, away from any clock edge.
        cycle("ar_a", 2, 0);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("async_mid");
        @(posedge clk);
        #1;
        check_all("async_hold");
        reset_n = 1'b1;

        // Randomised traffic with sparse events and occasional restarts.
        for (int i = 0; i < 400; i++) begin
            int a;
            int r;
            a = int'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = 0;
            r = ($urandom_range(0, 19) == 0) ? 1 : 0;
            cycle("rnd", a, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
